// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: elastic MEM/WB pipeline register with a pre-muxed
// write-back value, flush, and an optional 2-entry skid buffer.
//
// Ports:
//   clk, clr            clock (rising edge), async active-low reset
//   flush               synchronous squash of all held entries
//   in_valid/in_ready   MEM-side handshake
//   in_reg_write, in_mem_to_reg, in_write_reg, in_alu_out, in_dm_out
//                       incoming entry fields
//   out_valid/out_ready WB-side handshake
//   out_reg_write       head RegWrite, gated by out_valid
//   out_mem_to_reg, out_write_reg, out_alu_out, out_dm_out
//                       head entry fields
//   out_wb_data         out_mem_to_reg ? out_dm_out : out_alu_out
//
// Parameters:
//   DATA_W   data width
//   REG_W    destination register index width
//   SKID_EN  1 = 2-entry skid buffer, registered in_ready
//            0 = single entry, in_ready combinational from out_ready

module mem_wb_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 6,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [REG_W-1:0]  in_write_reg,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_dm_out,

    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic [REG_W-1:0]  out_write_reg,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_dm_out,
    output logic [DATA_W-1:0] out_wb_data
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state;

    // Head entry; rw_q already carries the out_valid gating.
    logic              valid_q;
    logic              rw_q;
    logic              m2r_q;
    logic [REG_W-1:0]  wr_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] dm_q;

    // Skid entry, only ever filled when SKID_EN != 0.
    logic              sk_rw_q;
    logic              sk_m2r_q;
    logic [REG_W-1:0]  sk_wr_q;
    logic [DATA_W-1:0] sk_alu_q;
    logic [DATA_W-1:0] sk_dm_q;

    logic              rdy_q;
    logic              in_xfer;
    logic              out_xfer;

    // rdy_q stays 1 when SKID_EN == 0 (TWO is unreachable), so the
    // single-entry form reduces to !out_valid | out_ready.
    always_comb begin
        if (SKID_EN != 0) begin
            in_ready = rdy_q;
        end else begin
            in_ready = rdy_q & (~valid_q | out_ready);
        end
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = valid_q & out_ready;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_EMPTY;
            valid_q  <= 1'b0;
            rdy_q    <= 1'b1;
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            wr_q     <= '0;
            alu_q    <= '0;
            dm_q     <= '0;
            sk_rw_q  <= 1'b0;
            sk_m2r_q <= 1'b0;
            sk_wr_q  <= '0;
            sk_alu_q <= '0;
            sk_dm_q  <= '0;
        end else if (flush) begin
            // Fields are left as-is; only validity matters.
            state   <= S_EMPTY;
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (in_xfer) begin
                        state   <= S_ONE;
                        valid_q <= 1'b1;
                        rw_q    <= in_reg_write;
                        m2r_q   <= in_mem_to_reg;
                        wr_q    <= in_write_reg;
                        alu_q   <= in_alu_out;
                        dm_q    <= in_dm_out;
                    end
                end
                S_ONE: begin
                    unique case (1'b1)
                        (in_xfer && out_xfer): begin
                            rw_q  <= in_reg_write;
                            m2r_q <= in_mem_to_reg;
                            wr_q  <= in_write_reg;
                            alu_q <= in_alu_out;
                            dm_q  <= in_dm_out;
                        end
                        (!in_xfer && out_xfer): begin
                            state   <= S_EMPTY;
                            valid_q <= 1'b0;
                            rw_q    <= 1'b0;
                        end
                        (in_xfer && !out_xfer): begin
                            // Head is stalled; park the newcomer behind it.
                            state    <= S_TWO;
                            rdy_q    <= 1'b0;
                            sk_rw_q  <= in_reg_write;
                            sk_m2r_q <= in_mem_to_reg;
                            sk_wr_q  <= in_write_reg;
                            sk_alu_q <= in_alu_out;
                            sk_dm_q  <= in_dm_out;
                        end
                        default: begin
                        end
                    endcase
                end
                S_TWO: begin
                    if (out_xfer) begin
                        state <= S_ONE;
                        rdy_q <= 1'b1;
                        rw_q  <= sk_rw_q;
                        m2r_q <= sk_m2r_q;
                        wr_q  <= sk_wr_q;
                        alu_q <= sk_alu_q;
                        dm_q  <= sk_dm_q;
                    end
                end
                default: begin
                    state   <= S_EMPTY;
                    valid_q <= 1'b0;
                    rw_q    <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign out_valid      = valid_q;
    assign out_reg_write  = rw_q;
    assign out_mem_to_reg = m2r_q;
    assign out_write_reg  = wr_q;
    assign out_alu_out    = alu_q;
    assign out_dm_out     = dm_q;
    assign out_wb_data    = m2r_q ? dm_q : alu_q;

endmodule
